iic_dri_arb: RTL and testbench
==============================

Name: iic_dri_arb

Overview:
- Round-robin arbiter and sequencer that shares one iic_dri I2C master between N_REQ independent requesters, for example an EEPROM test client, a config loader and a debug port.
- Latches the winning client's command and issues the single-cycle start pulse to iic_dri.
- Tracks iic_dri busy to detect completion, and routes byte_over, data_out and the per-byte write data to and from the granted client only.
- Sits between the client logic and the iic_dri instance, in the same clk domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_WIDTH, 8, byte-length field width; matches iic_dri (field is LEN_WIDTH+1 bits).
- START_TIMEOUT, 16, cycles allowed after the start pulse for iic_busy to rise.
- WDOG_CYCLES, 24'd5_000_000, maximum cycles iic_busy may stay high. Used only when IIC_ARB_WDOG_EN is defined.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous reset, active-high
- req_i  in  N_REQ  per-client request level; hold high until done_o
- w_r_i  in  N_REQ  per-client direction: 1 = write, 0 = read
- byte_len_i  in  N_REQ*(LEN_WIDTH+1)  per-client byte count, packed with client 0 in the LSBs
- addr_i  in  N_REQ*8  per-client word address, packed
- data_i  in  N_REQ*8  per-client write data, packed; the client may update it after each byte_over_o
- gnt_o  out  N_REQ  one-hot grant, high from START through DONE
- done_o  out  N_REQ  one-cycle completion pulse to the granted client
- err_o  out  N_REQ  one-cycle error pulse, coincident with done_o
- byte_over_o  out  N_REQ  iic_byte_over steered to the granted client
- data_o  out  8  iic_data_out broadcast; valid for the client that holds byte_over_o
- iic_pluse  out  1  start pulse to iic_dri
- iic_w_r  out  1  latched direction
- iic_byte_len  out  LEN_WIDTH+1  latched byte count
- iic_addr  out  8  latched address
- iic_data_in  out  8  data_i slice of the granted client, combinational mux
- iic_busy  in  1  from iic_dri
- iic_byte_over  in  1  from iic_dri
- iic_data_out  in  8  from iic_dri

Behaviour:
- Reset: rst is asynchronous, active-high. All outputs are 0. State = IDLE. Round-robin pointer = 0. Latched command = 0.
- IDLE:
  - When any req_i is high and iic_busy = 0, pick the first requesting client at or after the pointer, wrapping modulo N_REQ.
  - Latch that client's w_r, byte_len and addr, then go to START.
  - If iic_busy = 1, wait in IDLE.
- START (1 cycle): gnt_o[winner] = 1 and iic_pluse = 1. Latency from req_i sampled high in IDLE to iic_pluse is 1 cycle. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - When iic_busy = 1, go to RUN.
  - If START_TIMEOUT cycles elapse without busy, go to DONE with the error flag set.
- RUN:
  - Steer iic_byte_over to byte_over_o[winner]. iic_data_in follows data_i[winner] live.
  - When iic_busy = 0, go to DONE.
- DONE (1 cycle):
  - done_o[winner] = 1; err_o[winner] = error flag.
  - Pointer = winner+1, wrapping.
  - gnt_o is cleared on the next cycle. Next state is IDLE.
- Request drop mid-transaction: a req_i drop after START is ignored; the transaction completes and done_o still pulses.
- Repeat requests: a client still requesting after DONE is re-arbitrated behind the other requesters, which guarantees fairness.
- Simultaneous requests: the pointer decides. After a transaction by client k, client k+1 has highest priority.
- Zero-length requests: byte_len = 0 is forwarded unchanged; the error is detected only through the timeout.
- Reset mid-transaction: the arbiter returns to IDLE at once. iic_dri is reset separately by the top level.

Optional Feature:
- Macro IIC_ARB_WDOG_EN, defined: a watchdog counter runs in RUN.
  - If iic_busy stays high for WDOG_CYCLES, go to DONE with err = 1.
  - IDLE still waits for iic_busy = 0 before granting again.
- Macro not defined: RUN waits indefinitely, and no watchdog counter is built.

Decomposition:
- Package iic_arb_pkg holds:
  - state encodings IDLE/START/WAIT_BUSY/RUN/DONE (3-bit);
  - default N_REQ and LEN_WIDTH;
  - the pointer width function clog2.
- Sub-module rr_pick: combinational round-robin selector (req vector + pointer -> one-hot winner + index + any). It is reused by later arbiters.

Test Plan:
- Single request: client 1 requests a write, addr 0x00, len 8. Expect:
  - iic_pluse 1 cycle after req;
  - the model drives busy for 100 cycles, then done_o[1] pulses 1 cycle after busy falls;
  - err_o = 0.
- Contention: clients 0, 2 and 3 request together with pointer = 0. Expect grants in order 0, 2, 3, then 0 again if client 0 is still requesting. Each grant is exactly one-hot.
- Read steering: client 2 requests a read, len 4, and the model pulses byte_over 4 times with data 0xA5, 0x5A, 0x3C, 0xC3. Expect:
  - only byte_over_o[2] toggles;
  - data_o carries each byte;
  - iic_data_in equals data_i[2].
- Start timeout: the model never raises busy. Expect done_o and err_o to pulse START_TIMEOUT+1 cycles after iic_pluse, and the next requester is then granted.
- Reset mid-RUN: assert rst while busy is high. Expect:
  - gnt_o = 0 and iic_pluse = 0 asynchronously;
  - no done_o pulse;
  - pointer = 0 afterwards.
- With IIC_ARB_WDOG_EN defined and WDOG_CYCLES = 1000, hold busy high. Expect err_o pulse 1000 cycles after entering RUN, and no new grant until busy falls.

Source files
------------

// File: rtl/iic_dri_arb_pkg.sv
// Shared types and helpers for the iic_dri round-robin arbiter and its selector.
package iic_arb_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_LEN_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    RUN       = 3'd3,
    DONE      = 3'd4
  } arb_state_e;

  // Ceiling log2, never below 1 so a 1-entry range still gets a real bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iic_dri_arb_if.sv
// Command/status bus between the arbiter (master) and the shared iic_dri instance (slave).
interface iic_dri_arb_if
  import iic_arb_pkg::*;
#(
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) ();

  logic                 iic_pluse;
  logic                 iic_w_r;
  logic [LEN_WIDTH:0]   iic_byte_len;
  logic [7:0]           iic_addr;
  logic [7:0]           iic_data_in;
  logic                 iic_busy;
  logic                 iic_byte_over;
  logic [7:0]           iic_data_out;

  modport master (
    output iic_pluse, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    input  iic_busy, iic_byte_over, iic_data_out
  );

  modport slave (
    input  iic_pluse, iic_w_r, iic_byte_len, iic_addr, iic_data_in,
    output iic_busy, iic_byte_over, iic_data_out
  );

endinterface

// File: rtl/iic_dri_arb_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module rr_pick
  import iic_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [PTR_W:0] idx_sum;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    idx_sum = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (idx_sum >= (PTR_W+1)'(N_REQ)) idx_sum = idx_sum - (PTR_W+1)'(N_REQ);
      if (!any_o && req_i[idx_sum[PTR_W-1:0]]) begin
        any_o                        = 1'b1;
        idx_o                        = idx_sum[PTR_W-1:0];
        gnt_o[idx_sum[PTR_W-1:0]]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_dri_arb.sv
// Round-robin arbiter/sequencer sharing one iic_dri master among N_REQ clients.
// Define IIC_ARB_WDOG_EN to build a watchdog that aborts RUN after WDOG_CYCLES of busy.
module iic_dri_arb
  import iic_arb_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
  parameter int START_TIMEOUT = 16
`ifdef IIC_ARB_WDOG_EN
  , parameter logic [23:0] WDOG_CYCLES = 24'd5_000_000
`endif
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_i,
  input  logic [N_REQ-1:0]               w_r_i,
  input  logic [N_REQ*(LEN_WIDTH+1)-1:0] byte_len_i,
  input  logic [N_REQ*8-1:0]             addr_i,
  input  logic [N_REQ*8-1:0]             data_i,
  output logic [N_REQ-1:0]               gnt_o,
  output logic [N_REQ-1:0]               done_o,
  output logic [N_REQ-1:0]               err_o,
  output logic [N_REQ-1:0]               byte_over_o,
  output logic [7:0]                     data_o,
  iic_dri_arb_if.master                  iic
);

  localparam int PW = clog2(N_REQ);
  localparam int TW = clog2(START_TIMEOUT + 1);

  arb_state_e         state_q;
  logic [N_REQ-1:0]   gnt_q, done_q, err_q;
  logic [PW-1:0]      win_q, ptr_q, ptr_d;
  logic               pluse_q, w_r_q;
  logic [LEN_WIDTH:0] len_q;
  logic [7:0]         addr_q;
  logic [TW-1:0]      tmr_q;
`ifdef IIC_ARB_WDOG_EN
  logic [23:0]        wdog_q;
`endif

  logic [N_REQ-1:0]   pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;

  logic [LEN_WIDTH:0] len_arr  [N_REQ];
  logic [7:0]         addr_arr [N_REQ];
  logic [7:0]         data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign len_arr[g]  = byte_len_i[g*(LEN_WIDTH+1) +: LEN_WIDTH+1];
    assign addr_arr[g] = addr_i[g*8 +: 8];
    assign data_arr[g] = data_i[g*8 +: 8];
  end

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PW)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // The client just served drops to lowest priority for the next round.
  assign ptr_d = (win_q == PW'(N_REQ-1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      win_q   <= '0;
      ptr_q   <= '0;
      pluse_q <= 1'b0;
      w_r_q   <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
      tmr_q   <= '0;
`ifdef IIC_ARB_WDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      done_q  <= '0;
      err_q   <= '0;
      pluse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any && !iic.iic_busy) begin
            state_q <= START;
            gnt_q   <= pick_gnt;
            win_q   <= pick_idx;
            pluse_q <= 1'b1;
            w_r_q   <= w_r_i[pick_idx];
            len_q   <= len_arr[pick_idx];
            addr_q  <= addr_arr[pick_idx];
          end
        end
        START: begin
          state_q <= WAIT_BUSY;
          tmr_q   <= '0;
        end
        WAIT_BUSY: begin
          if (iic.iic_busy) begin
            state_q <= RUN;
`ifdef IIC_ARB_WDOG_EN
            wdog_q  <= '0;
`endif
          end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
            state_q <= DONE;
            done_q  <= gnt_q;
            err_q   <= gnt_q;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        RUN: begin
          if (!iic.iic_busy) begin
            state_q <= DONE;
            done_q  <= gnt_q;
          end
`ifdef IIC_ARB_WDOG_EN
          else if (wdog_q == WDOG_CYCLES - 24'd1) begin
            state_q <= DONE;
            done_q  <= gnt_q;
            err_q   <= gnt_q;
          end else begin
            wdog_q <= wdog_q + 24'd1;
          end
`endif
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          ptr_q   <= ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign byte_over_o = (state_q == RUN && iic.iic_byte_over) ? gnt_q : '0;
  assign data_o      = (state_q == RUN) ? iic.iic_data_out : 8'h00;

  assign iic.iic_pluse    = pluse_q;
  assign iic.iic_w_r      = w_r_q;
  assign iic.iic_byte_len = len_q;
  assign iic.iic_addr     = addr_q;
  assign iic.iic_data_in  = (state_q == IDLE) ? 8'h00 : data_arr[win_q];

endmodule

// File: tb/tb_iic_dri_arb.sv
// Directed bench for iic_dri_arb; the bench itself plays the iic_dri side of the bus.
module tb_iic_dri_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i, w_r_i;
  logic [35:0] byte_len_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  gnt_o, done_o, err_o, byte_over_o;
  logic [7:0]  data_o;
  int          checkCount;
  int          passCount;
  logic [7:0]  rdBytes [4];
  logic [7:0]  newData;

  iic_dri_arb_if #(.LEN_WIDTH(8)) iic ();

  iic_dri_arb #(.N_REQ(4), .LEN_WIDTH(8), .START_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .w_r_i       (w_r_i),
    .byte_len_i  (byte_len_i),
    .addr_i      (addr_i),
    .data_i      (data_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .byte_over_o (byte_over_o),
    .data_o      (data_o),
    .iic         (iic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input int client, input logic wr, input logic [8:0] len,
                               input logic [7:0] addr, input logic [7:0] data);
    w_r_i[client]             = wr;
    byte_len_i[client*9 +: 9] = len;
    addr_i[client*8 +: 8]     = addr;
    data_i[client*8 +: 8]     = data;
    req_i[client]             = 1'b1;
  endtask

  // Called on the negedge where the start pulse is due; ends on the negedge after DONE.
  task automatic runTxn(input logic [3:0] expGnt, input int busyCycles,
                        input logic [3:0] dropMask, input logic [7:0] expData);
    checkOutput("pluse", iic.iic_pluse, 1);
    checkOutput("gnt_start", gnt_o, expGnt);
    iic.iic_busy = 1'b1;
    @(negedge clk);
    checkOutput("pluse_clear", iic.iic_pluse, 0);
    @(negedge clk);
    checkOutput("data_in", iic.iic_data_in, expData);
    checkOutput("gnt_run", gnt_o, expGnt);
    repeat (busyCycles) @(negedge clk);
    checkOutput("no_early_done", done_o, 0);
    iic.iic_busy = 1'b0;
    @(negedge clk);
    checkOutput("done", done_o, expGnt);
    checkOutput("err_clear", err_o, 0);
    req_i = req_i & ~dropMask;
    @(negedge clk);
    checkOutput("gnt_release", gnt_o, 0);
    checkOutput("done_once", done_o, 0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rdBytes    = '{8'hA5, 8'h5A, 8'h3C, 8'hC3};
    rst        = 1'b1;
    req_i      = '0;
    w_r_i      = '0;
    byte_len_i = '0;
    addr_i     = '0;
    data_i     = 32'h13121110;
    iic.iic_busy      = 1'b0;
    iic.iic_byte_over = 1'b0;
    iic.iic_data_out  = 8'h00;

    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", gnt_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_pluse", iic.iic_pluse, 0);
    checkOutput("rst_len", iic.iic_byte_len, 0);
    checkOutput("rst_data_in", iic.iic_data_in, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write by client 1; request dropped after START must still complete.
    applyStimulus(1, 1'b1, 9'd8, 8'h00, 8'h11);
    @(negedge clk);
    checkOutput("t1_w_r", iic.iic_w_r, 1);
    checkOutput("t1_len", iic.iic_byte_len, 8);
    checkOutput("t1_addr", iic.iic_addr, 8'h00);
    req_i[1] = 1'b0;
    runTxn(4'b0010, 100, 4'b0000, 8'h11);

    // Read by client 2 with byte_over steering and live write-data mux.
    applyStimulus(2, 1'b0, 9'd4, 8'h80, 8'h77);
    @(negedge clk);
    checkOutput("rd_pluse", iic.iic_pluse, 1);
    checkOutput("rd_gnt", gnt_o, 4'b0100);
    checkOutput("rd_w_r", iic.iic_w_r, 0);
    checkOutput("rd_len", iic.iic_byte_len, 4);
    checkOutput("rd_addr", iic.iic_addr, 8'h80);
    iic.iic_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      iic.iic_data_out  = rdBytes[b];
      iic.iic_byte_over = 1'b1;
      #1;
      checkOutput("rd_byte_over", byte_over_o, 4'b0100);
      checkOutput("rd_data_o", data_o, rdBytes[b]);
      @(negedge clk);
      iic.iic_byte_over = 1'b0;
      newData           = 8'h80 | 8'(b);
      data_i[23:16]     = newData;
      #1;
      checkOutput("rd_byte_over_low", byte_over_o, 0);
      checkOutput("rd_data_in_live", iic.iic_data_in, newData);
      @(negedge clk);
    end
    iic.iic_busy = 1'b0;
    @(negedge clk);
    checkOutput("rd_done", done_o, 4'b0100);
    checkOutput("rd_err", err_o, 0);
    req_i[2] = 1'b0;
    @(negedge clk);
    checkOutput("rd_gnt_release", gnt_o, 0);

    // Start timeout: client 3 (pointer 3) never sees busy; client 0 waits behind it.
    applyStimulus(3, 1'b1, 9'd0, 8'hF0, 8'h33);
    applyStimulus(0, 1'b1, 9'd1, 8'h01, 8'h10);
    @(negedge clk);
    checkOutput("to_pluse", iic.iic_pluse, 1);
    checkOutput("to_gnt", gnt_o, 4'b1000);
    checkOutput("to_len_zero", iic.iic_byte_len, 0);
    repeat (16) @(negedge clk);
    checkOutput("to_no_early_done", done_o, 0);
    @(negedge clk);
    checkOutput("to_done", done_o, 4'b1000);
    checkOutput("to_err", err_o, 4'b1000);
    req_i[3] = 1'b0;
    @(negedge clk);
    checkOutput("to_gnt_release", gnt_o, 0);
    checkOutput("to_err_once", err_o, 0);
    @(negedge clk);
    runTxn(4'b0001, 10, 4'b0001, 8'h10);

    // Reset in the middle of RUN for client 1.
    applyStimulus(1, 1'b1, 9'd2, 8'h40, 8'h21);
    @(negedge clk);
    checkOutput("rr_gnt", gnt_o, 4'b0010);
    iic.iic_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rr_gnt_run", gnt_o, 4'b0010);
    #2 rst = 1'b1;
    #1;
    checkOutput("rr_async_gnt", gnt_o, 0);
    checkOutput("rr_async_pluse", iic.iic_pluse, 0);
    checkOutput("rr_async_addr", iic.iic_addr, 0);
    @(negedge clk);
    checkOutput("rr_no_done", done_o, 0);
    iic.iic_busy = 1'b0;
    req_i        = '0;
    @(negedge clk);
    checkOutput("rr_no_done_late", done_o, 0);
    rst = 1'b0;

    // Contention with pointer back at 0: order 0, 2, 3, then 0 again.
    applyStimulus(0, 1'b1, 9'd2, 8'h00, 8'h10);
    applyStimulus(2, 1'b1, 9'd3, 8'h20, 8'h12);
    applyStimulus(3, 1'b1, 9'd4, 8'h30, 8'h13);
    @(negedge clk);
    runTxn(4'b0001, 20, 4'b0000, 8'h10);
    @(negedge clk);
    runTxn(4'b0100, 20, 4'b0100, 8'h12);
    @(negedge clk);
    runTxn(4'b1000, 20, 4'b1000, 8'h13);
    @(negedge clk);
    runTxn(4'b0001, 20, 4'b0001, 8'h10);
    @(negedge clk);
    checkOutput("idle_no_pluse", iic.iic_pluse, 0);
    checkOutput("idle_no_gnt", gnt_o, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
